// File: rtl/dct_mac_sequencer.sv
// Issue/capture sequencer for the shared DCT multiply-accumulate unit: 8x8 term
// issue per row, latency-matched result capture and a 2-entry result buffer.
//
// state   | meaning
// S_IDLE  | waiting for a row; row_ready high
// S_ISSUE | stepping k (outer) and n (inner) terms into the MAC unit
module dct_mac_sequencer #(
   parameter int ACC_W   = 22,
   parameter int MAC_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             row_valid,
   output logic             row_ready,
   output logic [2:0]       smp_sel,
   output logic [5:0]       coef_addr,
   output logic             mac_en,
   output logic             acc_clr,
   input  logic [ACC_W-1:0] acc_val,
   output logic [ACC_W-1:0] res,
   output logic [2:0]       res_k,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);
   typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [2:0]         k_q, k_d, n_q, n_d;
   logic [MAC_LAT-1:0] dl_vld_q, dl_vld_d;
   logic [2:0]         dl_tag_q [MAC_LAT];
   logic [2:0]         dl_tag_d [MAC_LAT];
   logic [ACC_W-1:0]   buf_val_q [2];
   logic [ACC_W-1:0]   buf_val_d [2];
   logic [2:0]         buf_k_q [2];
   logic [2:0]         buf_k_d [2];
   logic [1:0]         cnt_q, cnt_d;
   logic [1:0]         infl_q, infl_d;

   logic       issuing, stall, last_term, accept, capture, pop, wr_slot;
   logic [2:0] credit_used;

   always_comb begin
      issuing     = (state_q == S_ISSUE);
      credit_used = {1'b0, cnt_q} + {1'b0, infl_q};
      // a new group may only start if its result is guaranteed a buffer slot
      stall       = issuing && (n_q == 3'd0) && (credit_used >= 3'd2);
      last_term   = issuing && (k_q == 3'd7) && (n_q == 3'd7);
      row_ready   = !issuing || last_term;
      accept      = row_valid && row_ready;
      mac_en      = issuing && !stall;
      acc_clr     = mac_en && (n_q == 3'd0);
      smp_sel     = n_q;
      coef_addr   = {k_q, n_q};
      capture     = dl_vld_q[MAC_LAT-1];
      res_valid   = (cnt_q != 2'd0);
      pop         = res_valid && res_ready;
      res         = buf_val_q[0];
      res_k       = buf_k_q[0];
      busy        = issuing || (infl_q != 2'd0);
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      n_d     = n_q;
      if (!issuing) begin
         if (accept) begin
            state_d = S_ISSUE;
            k_d     = 3'd0;
            n_d     = 3'd0;
         end
      end else if (mac_en) begin
         {k_d, n_d} = {k_q, n_q} + 6'd1;
         if (last_term && !accept) state_d = S_IDLE;
      end

      dl_vld_d[0] = mac_en && (n_q == 3'd7);
      dl_tag_d[0] = k_q;
      for (int i = 1; i < MAC_LAT; i++) begin
         dl_vld_d[i] = dl_vld_q[i-1];
         dl_tag_d[i] = dl_tag_q[i-1];
      end

      infl_d = infl_q + {1'b0, acc_clr} - {1'b0, capture};

      // head lives in slot 0; a pop shifts slot 1 down before any push lands
      buf_val_d = buf_val_q;
      buf_k_d   = buf_k_q;
      if (pop) begin
         buf_val_d[0] = buf_val_q[1];
         buf_k_d[0]   = buf_k_q[1];
      end
      wr_slot = cnt_q[1] || (cnt_q[0] && !pop);
      if (capture) begin
         buf_val_d[wr_slot] = acc_val;
         buf_k_d[wr_slot]   = dl_tag_q[MAC_LAT-1];
      end
      cnt_d = cnt_q + {1'b0, capture} - {1'b0, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         n_q      <= '0;
         dl_vld_q <= '0;
         for (int i = 0; i < MAC_LAT; i++) dl_tag_q[i] <= '0;
         for (int i = 0; i < 2; i++) begin
            buf_val_q[i] <= '0;
            buf_k_q[i]   <= '0;
         end
         cnt_q    <= '0;
         infl_q   <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         n_q       <= n_d;
         dl_vld_q  <= dl_vld_d;
         dl_tag_q  <= dl_tag_d;
         buf_val_q <= buf_val_d;
         buf_k_q   <= buf_k_d;
         cnt_q     <= cnt_d;
         infl_q    <= infl_d;
      end
   end
endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Bench for dct_mac_sequencer: MAC_LAT=2 main instance with a term/result model,
// plus MAC_LAT=1 and MAC_LAT=4 instances used for the single-row latency sweep.
module tb_dct_mac_sequencer;
   localparam int ACC_W = 22;
   localparam int NI    = 3;
   localparam int LAT [NI] = '{2, 1, 4};

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic rst_aux   = 1'b1;
   logic row_valid = 1'b0;
   logic res_ready = 1'b1;

   logic             row_ready [NI];
   logic             mac_en    [NI];
   logic             acc_clr   [NI];
   logic             res_valid [NI];
   logic             busy      [NI];
   logic [2:0]       smp_sel   [NI];
   logic [2:0]       res_k     [NI];
   logic [5:0]       coef_addr [NI];
   logic [ACC_W-1:0] res       [NI];
   logic [ACC_W-1:0] acc_val   [NI] = '{default: '0};

   always #5 clk = ~clk;

   dct_mac_sequencer #(.ACC_W(ACC_W), .MAC_LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .row_valid(row_valid), .row_ready(row_ready[0]),
      .smp_sel(smp_sel[0]), .coef_addr(coef_addr[0]), .mac_en(mac_en[0]),
      .acc_clr(acc_clr[0]), .acc_val(acc_val[0]), .res(res[0]), .res_k(res_k[0]),
      .res_valid(res_valid[0]), .res_ready(res_ready), .busy(busy[0]));

   dct_mac_sequencer #(.ACC_W(ACC_W), .MAC_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst_aux), .row_valid(row_valid), .row_ready(row_ready[1]),
      .smp_sel(smp_sel[1]), .coef_addr(coef_addr[1]), .mac_en(mac_en[1]),
      .acc_clr(acc_clr[1]), .acc_val(acc_val[1]), .res(res[1]), .res_k(res_k[1]),
      .res_valid(res_valid[1]), .res_ready(res_ready), .busy(busy[1]));

   dct_mac_sequencer #(.ACC_W(ACC_W), .MAC_LAT(4)) u_lat4 (
      .clk(clk), .rst(rst_aux), .row_valid(row_valid), .row_ready(row_ready[2]),
      .smp_sel(smp_sel[2]), .coef_addr(coef_addr[2]), .mac_en(mac_en[2]),
      .acc_clr(acc_clr[2]), .acc_val(acc_val[2]), .res(res[2]), .res_k(res_k[2]),
      .res_valid(res_valid[2]), .res_ready(res_ready), .busy(busy[2]));

   // MAC unit model: row samples latched on acceptance, coefficient ROM = k+1
   int unsigned      smp_in  [8] = '{default: 0};
   int unsigned      smp_lat [8] = '{default: 0};
   logic             pv [NI][4] = '{default: '{default: 1'b0}};
   logic             pc [NI][4] = '{default: '{default: 1'b0}};
   logic [ACC_W-1:0] pp [NI][4] = '{default: '{default: '0}};

   function automatic logic [ACC_W-1:0] term(input logic [2:0] s, input logic [5:0] a);
      return ACC_W'(smp_lat[s] * (32'(a[5:3]) + 32'd1));
   endfunction

   always @(posedge clk) begin
      if (row_valid && row_ready[0]) smp_lat <= smp_in;
      for (int i = 0; i < NI; i++) begin
         pv[i][0] <= mac_en[i];
         pc[i][0] <= acc_clr[i];
         pp[i][0] <= term(smp_sel[i], coef_addr[i]);
         for (int j = 1; j < 4; j++) begin
            pv[i][j] <= pv[i][j-1];
            pc[i][j] <= pc[i][j-1];
            pp[i][j] <= pp[i][j-1];
         end
         if (LAT[i] == 1) begin
            if (mac_en[i])
               acc_val[i] <= acc_clr[i] ? term(smp_sel[i], coef_addr[i])
                                        : acc_val[i] + term(smp_sel[i], coef_addr[i]);
         end else if (pv[i][LAT[i]-2]) begin
            acc_val[i] <= pc[i][LAT[i]-2] ? pp[i][LAT[i]-2] : acc_val[i] + pp[i][LAT[i]-2];
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   typedef struct {
      int               k;
      logic [ACC_W-1:0] v;
   } res_t;

   logic [5:0] tq [$];
   res_t       rq [$];
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit base_set;
   int base_cyc, n_acc, n_mac, n_clr, n_rr, open_g;
   int first_mac_rel, last_mac_rel, mac17_rel;
   int acc_rel [4];
   int pop_n   [NI];
   int pop_rel [NI][16];
   logic [ACC_W-1:0] pop_val [NI][16];
   logic [2:0]       pop_k   [NI][16];

   task automatic new_phase();
      base_set = 0; n_acc = 0; n_mac = 0; n_clr = 0; n_rr = 0;
      first_mac_rel = -1; last_mac_rel = -1; mac17_rel = -1;
      for (int i = 0; i < NI; i++) pop_n[i] = 0;
   endtask

   always @(negedge clk) begin : mon
      int rel;
      logic [5:0] e_t;
      res_t e_r;
      int unsigned sum;
      rel = cyc - base_cyc;
      if (rst) begin
         tq.delete();
         rq.delete();
         open_g = 0;
         chk("rst_mac_en", 32'(mac_en[0]), 0);
         chk("rst_res_valid", 32'(res_valid[0]), 0);
      end else begin
         if (row_valid && row_ready[0]) begin
            if (!base_set) begin
               base_set = 1;
               base_cyc = cyc;
               rel = 0;
            end
            if (n_acc < 4) acc_rel[n_acc] = rel;
            n_acc++;
            for (int k = 0; k < 8; k++) begin
               sum = 0;
               for (int n = 0; n < 8; n++) begin
                  tq.push_back(6'(k * 8 + n));
                  sum += smp_in[n] * 32'(k + 1);
               end
               e_r.k = k;
               e_r.v = ACC_W'(sum);
               rq.push_back(e_r);
            end
         end
         if (mac_en[0]) begin
            n_mac++;
            if (n_mac == 1) first_mac_rel = rel;
            if (n_mac == 17) mac17_rel = rel;
            last_mac_rel = rel;
            if (acc_clr[0]) n_clr++;
            if (smp_sel[0] == 3'd0) open_g++;
            chk("term_avail", 32'(tq.size() != 0), 1);
            if (tq.size() != 0) begin
               e_t = tq.pop_front();
               chk("coef_addr", 32'(coef_addr[0]), 32'(e_t));
               chk("smp_sel", 32'(smp_sel[0]), 32'(e_t[2:0]));
               chk("acc_clr", 32'(acc_clr[0]), 32'(e_t[2:0] == 3'd0));
            end
         end else begin
            chk("acc_clr_idle", 32'(acc_clr[0]), 0);
         end
         if (res_valid[0] && res_ready) begin
            open_g--;
            chk("res_avail", 32'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
               e_r = rq.pop_front();
               chk("res", 32'(res[0]), 32'(e_r.v));
               chk("res_k", 32'(res_k[0]), 32'(e_r.k));
            end
         end
         chk("groups_le2", 32'(open_g <= 2), 1);
         if (base_set && rel >= 1 && rel <= 127 && row_ready[0]) n_rr++;
      end
      for (int i = 0; i < NI; i++) begin
         if (res_valid[i] && res_ready) begin
            if (pop_n[i] < 16) begin
               pop_rel[i][pop_n[i]] = rel;
               pop_val[i][pop_n[i]] = res[i];
               pop_k[i][pop_n[i]]   = res_k[i];
            end
            pop_n[i]++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_row();
      bit ok;
      ok = 0;
      row_valid = 1'b1;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clk);
         if (row_ready[0]) ok = 1;
         @(posedge clk);
         #2;
      end
      chk("row_accepted", 32'(ok), 1);
   endtask

   task automatic wait_pops(input int n, input int budget);
      for (int c = 0; c < budget && pop_n[0] < n; c++) tick(1);
      chk("pops_reached", 32'(pop_n[0] >= n), 1);
   endtask

   task automatic chk_reset_outputs(input int i);
      chk("rst_row_ready", 32'(row_ready[i]), 1);
      chk("rst_mac_en_now", 32'(mac_en[i]), 0);
      chk("rst_acc_clr", 32'(acc_clr[i]), 0);
      chk("rst_smp_sel", 32'(smp_sel[i]), 0);
      chk("rst_coef_addr", 32'(coef_addr[i]), 0);
      chk("rst_res_valid_now", 32'(res_valid[i]), 0);
      chk("rst_res", 32'(res[i]), 0);
      chk("rst_res_k", 32'(res_k[i]), 0);
      chk("rst_busy", 32'(busy[i]), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired got 1 expected 0");
      $fatal(1, "watchdog");
   end

   initial begin
      bit all_done;
      new_phase();
      tick(3);
      for (int i = 0; i < NI; i++) chk_reset_outputs(i);

      // single row, all three latencies
      smp_in = '{1, 1, 1, 1, 1, 1, 1, 1};
      rst = 1'b0;
      rst_aux = 1'b0;
      tick(2);
      new_phase();
      send_row();
      row_valid = 1'b0;
      all_done = 0;
      for (int c = 0; c < 200 && !all_done; c++) begin
         tick(1);
         all_done = (pop_n[0] >= 8) && (pop_n[1] >= 8) && (pop_n[2] >= 8);
      end
      chk("t1_all_done", 32'(all_done), 1);
      for (int k = 0; k < 8; k++) begin
         chk("t1_rel_lat2", 32'(pop_rel[0][k]), 32'(11 + 8 * k));
         chk("t1_val_lat2", 32'(pop_val[0][k]), 32'(8 * (k + 1)));
         chk("t1_k_lat2", 32'(pop_k[0][k]), 32'(k));
         chk("t1_rel_lat1", 32'(pop_rel[1][k]), 32'(10 + 8 * k));
         chk("t1_val_lat1", 32'(pop_val[1][k]), 32'(8 * (k + 1)));
         chk("t1_rel_lat4", 32'(pop_rel[2][k]), 32'(13 + 8 * k));
         chk("t1_val_lat4", 32'(pop_val[2][k]), 32'(8 * (k + 1)));
      end
      chk("t1_mac_cnt", 32'(n_mac), 64);
      chk("t1_clr_cnt", 32'(n_clr), 8);
      chk("t1_busy_end", 32'(busy[0]), 0);
      rst_aux = 1'b1;

      // back-to-back rows
      tick(2);
      new_phase();
      smp_in = '{0, 1, 2, 3, 4, 5, 6, 7};
      send_row();
      smp_in = '{2, 2, 2, 2, 2, 2, 2, 2};
      send_row();
      row_valid = 1'b0;
      wait_pops(16, 250);
      chk("t2_second_accept", 32'(acc_rel[1]), 64);
      chk("t2_mac_cnt", 32'(n_mac), 128);
      chk("t2_first_mac", 32'(first_mac_rel), 1);
      chk("t2_last_mac", 32'(last_mac_rel), 128);
      chk("t2_row_ready_pulses", 32'(n_rr), 1);
      chk("t2_row1_first_rel", 32'(pop_rel[0][0]), 11);
      chk("t2_row1_val0", 32'(pop_val[0][0]), 28);
      chk("t2_row2_first_rel", 32'(pop_rel[0][8]), 75);
      chk("t2_row2_last_rel", 32'(pop_rel[0][15]), 131);
      chk("t2_row2_val0", 32'(pop_val[0][8]), 16);
      chk("t2_row2_val7", 32'(pop_val[0][15]), 128);

      // backpressure
      tick(2);
      new_phase();
      res_ready = 1'b0;
      smp_in = '{3, 1, 4, 1, 5, 9, 2, 6};
      send_row();
      row_valid = 1'b0;
      tick(30);
      chk("t3_mac_cnt_stalled", 32'(n_mac), 16);
      chk("t3_last_mac", 32'(last_mac_rel), 16);
      chk("t3_res_valid", 32'(res_valid[0]), 1);
      chk("t3_head_k", 32'(res_k[0]), 0);
      chk("t3_head_val", 32'(res[0]), 31);
      chk("t3_busy", 32'(busy[0]), 1);
      res_ready = 1'b1;
      wait_pops(8, 200);
      chk("t3_resume_after_pop", 32'(mac17_rel), 32'(pop_rel[0][0] + 1));
      chk("t3_second_buffered", 32'(pop_rel[0][1]), 32'(pop_rel[0][0] + 1));
      chk("t3_k1", 32'(pop_k[0][1]), 1);
      chk("t3_val7", 32'(pop_val[0][7]), 248);

      // res_ready toggling every cycle
      tick(2);
      new_phase();
      smp_in = '{1, 2, 3, 4, 5, 6, 7, 8};
      send_row();
      row_valid = 1'b0;
      for (int c = 0; c < 300 && pop_n[0] < 8; c++) begin
         res_ready = ~res_ready;
         tick(1);
      end
      res_ready = 1'b1;
      tick(6);
      chk("t4_pop_cnt", 32'(pop_n[0]), 8);
      for (int k = 0; k < 8; k++) chk("t4_k_order", 32'(pop_k[0][k]), 32'(k));
      chk("t4_val3", 32'(pop_val[0][3]), 144);
      chk("t4_drained", 32'(res_valid[0]), 0);

      // mid-row reset
      tick(2);
      new_phase();
      smp_in = '{2, 2, 2, 2, 2, 2, 2, 2};
      send_row();
      row_valid = 1'b0;
      tick(29);
      rst = 1'b1;
      #1;
      chk_reset_outputs(0);
      chk("t5_pops_before_rst", 32'(pop_n[0]), 3);
      tick(3);
      rst = 1'b0;
      tick(10);
      chk("t5_no_pops_after", 32'(pop_n[0]), 3);
      chk("t5_mac_cnt", 32'(n_mac), 29);
      chk("t5_res_valid_low", 32'(res_valid[0]), 0);
      new_phase();
      smp_in = '{7, 0, 1, 0, 2, 0, 3, 1};
      send_row();
      row_valid = 1'b0;
      wait_pops(8, 200);
      chk("t5_new_first_rel", 32'(pop_rel[0][0]), 11);
      chk("t5_new_val0", 32'(pop_val[0][0]), 14);
      chk("t5_new_val7", 32'(pop_val[0][7]), 112);
      tick(5);
      chk("final_res_queue", 32'(rq.size()), 0);
      chk("final_term_queue", 32'(tq.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
